// File: rtl/me_sched.sv
// me_sched: sequences one motion-estimation block: loads 16 current rows, streams
// 23 reference-window rows into the SAD core, then hands off the captured result.
module me_sched #(
  parameter int CORE_LAT = 4,
  parameter int FRAME_H  = 2160,
  parameter int VOFF     = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req_valid,
  output logic          o_req_ready,
  input  logic [8:0]    i_req_blk_x,
  input  logic [7:0]    i_req_blk_y,
  output logic          o_cur_rd_en,
  output logic [11:0]   o_cur_rd_row,
  output logic [8:0]    o_cur_rd_col,
  input  logic [63:0]   i_cur_rd_data,
  output logic          o_ref_rd_en,
  output logic [11:0]   o_ref_rd_row,
  output logic [8:0]    o_ref_rd_col,
  input  logic [183:0]  i_ref_rd_data,
  output logic          o_core_rst,
  output logic [1023:0] o_crt_block,
  output logic [183:0]  o_data_in,
  input  logic [13:0]   i_core_sad,
  input  logic [3:0]    i_core_mv_x,
  input  logic [3:0]    i_core_mv_y,
  output logic          o_res_valid,
  input  logic          i_res_ready,
  output logic [13:0]   o_res_sad,
  output logic [3:0]    o_res_mv_x,
  output logic [3:0]    o_res_mv_y,
  output logic [8:0]    o_res_blk_x,
  output logic [7:0]    o_res_blk_y
);
  typedef enum logic [2:0] {IDLE, LOAD, FEED, DRAIN, OUT} state_t;
  localparam logic [7:0]         DRAIN_END = 8'(CORE_LAT + 1);
  localparam logic signed [14:0] VOFF_S    = 15'(VOFF);
  localparam logic signed [14:0] FRAME_S   = 15'(FRAME_H);
  state_t              r_state, w_nxt;
  logic [7:0]          r_cnt;
  logic [8:0]          r_blk_x;
  logic [7:0]          r_blk_y;
  logic                r_cur_v, r_ref_v, r_ref_oor, r_core_rst;
  logic [3:0]          r_cur_k;
  logic [1023:0]       r_crt;
  logic [183:0]        r_data_in;
  logic [13:0]         r_sad;
  logic [3:0]          r_mv_x, r_mv_y;
  logic signed [14:0]  w_row;
  logic                w_oor;
  logic                w_drain_end;
  // Signed window row so rows above the frame top are detectable.
  assign w_row       = $signed({3'b0, r_blk_y, 4'b0}) - VOFF_S + $signed({7'b0, r_cnt});
  assign w_oor       = (w_row < 0) || (w_row >= FRAME_S);
  assign w_drain_end = (r_state == DRAIN) && (r_cnt == DRAIN_END);
  always_comb begin
    w_nxt        = r_state;
    o_req_ready  = r_state == IDLE;
    o_cur_rd_en  = r_state == LOAD;
    o_cur_rd_row = {r_blk_y, r_cnt[3:0]};
    o_cur_rd_col = r_blk_x;
    o_ref_rd_en  = (r_state == FEED) && !w_oor;
    o_ref_rd_row = w_row[11:0];
    o_ref_rd_col = r_blk_x;
    o_res_valid  = r_state == OUT;
    case (r_state)
      IDLE:    w_nxt = i_req_valid ? LOAD : IDLE;
      LOAD:    w_nxt = (r_cnt == 8'd15) ? FEED : LOAD;
      FEED:    w_nxt = (r_cnt == 8'd22) ? DRAIN : FEED;
      DRAIN:   w_nxt = w_drain_end ? OUT : DRAIN;
      OUT:     w_nxt = i_res_ready ? IDLE : OUT;
      default: w_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_blk_x    <= '0;
      r_blk_y    <= '0;
      r_cur_v    <= 1'b0;
      r_cur_k    <= '0;
      r_ref_v    <= 1'b0;
      r_ref_oor  <= 1'b0;
      r_crt      <= '0;
      r_data_in  <= '0;
      r_core_rst <= 1'b1;
      r_sad      <= '0;
      r_mv_x     <= '0;
      r_mv_y     <= '0;
    end else begin
      r_state   <= w_nxt;
      r_cnt     <= (w_nxt != r_state) ? 8'd0 : r_cnt + 8'd1;
      r_cur_v   <= r_state == LOAD;
      r_cur_k   <= r_cnt[3:0];
      r_ref_v   <= r_state == FEED;
      r_ref_oor <= w_oor;
      if (r_state == IDLE && i_req_valid) begin
        r_blk_x <= i_req_blk_x;
        r_blk_y <= i_req_blk_y;
      end
      if (r_cur_v) r_crt[{~r_cur_k, 6'b0} +: 64] <= i_cur_rd_data;
      if (r_ref_v) r_data_in <= r_ref_oor ? '0 : i_ref_rd_data;
      // Core runs from the third FEED cycle through the capture cycle.
      r_core_rst <= !(((r_state == FEED) && (r_cnt != 8'd0)) || ((r_state == DRAIN) && !w_drain_end));
      if (w_drain_end) begin
        r_sad  <= i_core_sad;
        r_mv_x <= i_core_mv_x;
        r_mv_y <= i_core_mv_y;
      end
    end
  end
  assign o_core_rst  = r_core_rst;
  assign o_crt_block = r_crt;
  assign o_data_in   = r_data_in;
  assign o_res_sad   = r_sad;
  assign o_res_mv_x  = r_mv_x;
  assign o_res_mv_y  = r_mv_y;
  assign o_res_blk_x = r_blk_x;
  assign o_res_blk_y = r_blk_y;
endmodule

// File: doc/me_sched.md
ME_SCHED -- requirements
Module: me_sched

Interface
REQ-001 Parameters (name, default, meaning):
  CORE_LAT 4: core cycles from last data_in row to valid sad_min/motion_vec.
  FRAME_H 2160: frame height in lines.
  VOFF 4: vertical search offset; ref row 0 = blk_y*16 - VOFF.
REQ-002 Ports (name direction width meaning), one clock, synchronous active-high reset:
  clk in 1 clock, rising edge.
  rst in 1 synchronous, active-high reset.
  req_valid in 1 block request valid.
  req_ready out 1 request accepted when both high.
  req_blk_x in 9 block column (8-pixel units).
  req_blk_y in 8 block row (16-line units).
  cur_rd_en out 1 current-frame row read strobe.
  cur_rd_row out 12 current-frame line index.
  cur_rd_col out 9 block column for the read.
  cur_rd_data in 64 row data, one cycle after cur_rd_en.
  ref_rd_en out 1 reference-window row read strobe.
  ref_rd_row out 12 reference line index.
  ref_rd_col out 9 window column for the read.
  ref_rd_data in 184 23-pixel window row, one cycle after ref_rd_en.
  core_rst out 1 reset to core, active high.
  crt_block out 1024 16 current rows, row 0 in bits [1023:960].
  data_in out 184 window row to core, pixel 0 in MSBs.
  core_sad in 14 core sad_min.
  core_mv_x in 4 core motion_vec_x_min.
  core_mv_y in 4 core motion_vec_y_min.
  res_valid out 1 result valid.
  res_ready in 1 result consumed when both high.
  res_sad out 14, res_mv_x out 4, res_mv_y out 4 captured result.
  res_blk_x out 9, res_blk_y out 8 echo of request coordinates.

Function
REQ-003 States IDLE, LOAD, FEED, DRAIN, OUT; req_ready = (state==IDLE).
REQ-004 IDLE: on req_valid&&req_ready at cycle A, register blk_x/blk_y, go LOAD at A+1.
REQ-005 LOAD: 16 cycles; k-th cycle (k=0..15) cur_rd_en=1, cur_rd_row=blk_y*16+k, cur_rd_col=blk_x; then FEED.
REQ-006 cur_rd_data returned in cycle after issue of row k written to crt_block row k; crt_block otherwise holds.
REQ-007 FEED: 23 cycles starting F=A+17; k-th cycle (k=0..22) targets signed row r=blk_y*16-VOFF+k, ref_rd_col=blk_x.
REQ-008 r<0 or r>=FRAME_H: ref_rd_en=0, row flagged out-of-range; else ref_rd_en=1, ref_rd_row=r[11:0].
REQ-009 data_in is registered: row k presented in cycle F+k+2, equal to ref_rd_data, or all zeros if flagged out-of-range.
REQ-010 core_rst registered: 1 in IDLE, LOAD, OUT, first two FEED cycles; 0 from F+2 until result capture.
REQ-011 DRAIN: follows FEED, lasts 2+CORE_LAT cycles; data_in holds last row; ref/cur_rd_en=0.
REQ-012 core_sad/mv captured at end of cycle F+24+CORE_LAT; res_valid=1 from next cycle (A+42+CORE_LAT), state OUT.
REQ-013 OUT: res_* stable while res_valid&&!res_ready; on handshake res_valid=0 next cycle, state IDLE.
REQ-014 No request accepted outside IDLE; req_valid ignored mid-operation, accepted-to-result cycle count fixed.
REQ-015 At most one of cur_rd_en, ref_rd_en high in any cycle.

Reset
REQ-016 rst sampled at rising edge; next cycle: state IDLE, req_ready=1, cur_rd_en=0, ref_rd_en=0, core_rst=1, res_valid=0, data_in=0, crt_block=0, res_*=0.
REQ-017 rst mid-operation (any state) aborts block, no result emitted; rst overrides simultaneous req_valid.

Verification
REQ-018 Interior blk (5,5), CORE_LAT=4, res_ready=1 -> cur rows 80..95, ref rows 76..98 in order, data_in rows at F+2..F+24, res_valid at A+46 with core values and blk (5,5).
REQ-019 Top edge blk_y=0 -> rows -4..-1 not read, data_in=0 in F+2..F+5, ref_rd_row 0 at FEED cycle 4.
REQ-020 Bottom edge blk_y=134 -> ref rows 2140..2159 read, rows 2160..2162 not read, last three data_in rows zero.
REQ-021 res_ready low 10 cycles in OUT -> res_* stable, req_ready=0, req_valid ignored; IDLE cycle after handshake.
REQ-022 rst pulse at cycle F+10 -> next cycle IDLE, all strobes 0, core_rst=1, no res_valid; new request then runs normally.
REQ-023 Back-to-back req_valid held high -> second accept exactly one cycle after first result handshake.
